// File: rtl/axi_pkg.sv
// Shared constants, FSM state type and width helpers for the AXI4 write master.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_STRB_W = DEF_DATA_W / 8;
    localparam int DEF_SIZE_MAX = $clog2(DEF_STRB_W);
    localparam int TMO_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axi_write_master_if.sv
// LSU request/beat/completion signals plus the AXI4 AW, W and B channels.
interface axi_write_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8
);
    localparam int STRB_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [2:0]        req_size;

    logic              beat_valid;
    logic              beat_ready;
    logic [DATA_W-1:0] beat_data;
    logic [STRB_W-1:0] beat_strb;

    logic              done;
    logic [1:0]        resp;

    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [ID_W-1:0]   AWID;
    logic [LEN_W-1:0]  AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;

    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;

    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic [ID_W-1:0]   BID;

    modport master (
        input  req_valid, req_addr, req_len, req_size,
        output req_ready,
        input  beat_valid, beat_data, beat_strb,
        output beat_ready,
        output done, resp,
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST,
        input  WREADY,
        input  BVALID, BRESP, BID,
        output BREADY
    );

    modport slave (
        output req_valid, req_addr, req_len, req_size,
        input  req_ready,
        output beat_valid, beat_data, beat_strb,
        input  beat_ready,
        input  done, resp,
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST,
        output WREADY,
        output BVALID, BRESP, BID,
        input  BREADY
    );

endinterface

// File: rtl/axi_skid_reg.sv
// One-entry valid/ready register slice: refills in the same cycle its entry drains.
module axi_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign load        = in_valid_i && in_ready_o;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axi_write_master.sv
// Registered AXI4 write master: one request becomes one INCR burst, completion reported via done/resp.
// Define AXI_WR_TIMEOUT_EN to add a 16-bit watchdog that aborts a stalled transaction with SLVERR.
module axi_write_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8,
    parameter int AXI_ID = 0
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axi_write_master_if.master bus
);
    localparam int STRB_W = strb_width(DATA_W);
    localparam int SKID_W = STRB_W + DATA_W + 1;

    wr_state_e         state_q, state_d;
    logic              awvalid_q, awvalid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [LEN_W-1:0]  awlen_q, awlen_d;
    logic [2:0]        awsize_q, awsize_d;
    logic              aw_done_q, aw_done_d;
    logic              wlast_done_q, wlast_done_d;
    logic              last_loaded_q, last_loaded_d;
    logic [LEN_W:0]    cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [1:0]        resp_q, resp_d;

    logic              aw_hs, w_hs, wlast_hs, b_hs, tmo_fire;
    logic              accepting, skid_in_valid, skid_in_ready, beat_hs, wvalid;
    logic [SKID_W-1:0] skid_in, skid_out;
    logic              unused_bid;

    assign aw_hs     = awvalid_q && bus.AWREADY;
    assign w_hs      = wvalid && bus.WREADY;
    assign wlast_hs  = w_hs && skid_out[0];
    assign b_hs      = (state_q == RESP) && bus.BVALID;
    assign unused_bid = ^bus.BID;

    // Stop taking beats once the WLAST beat has entered the slice.
    assign accepting     = (state_q == XFER) && !last_loaded_q;
    assign skid_in_valid = bus.beat_valid && accepting;
    assign bus.beat_ready = accepting && skid_in_ready;
    assign beat_hs       = skid_in_valid && skid_in_ready;
    assign skid_in       = {bus.beat_strb, bus.beat_data, (cnt_q == {1'b0, awlen_q})};

    axi_skid_reg #(.W(SKID_W)) u_w_skid (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .flush_i    (tmo_fire),
        .in_valid_i (skid_in_valid),
        .in_ready_o (skid_in_ready),
        .in_data_i  (skid_in),
        .out_valid_o(wvalid),
        .out_ready_i(bus.WREADY),
        .out_data_o (skid_out)
    );

`ifdef AXI_WR_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q + TMO_W'(1);
        if (state_q == IDLE || aw_hs || w_hs || b_hs) tmo_d = '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    assign tmo_fire = (state_q != IDLE) && (tmo_q == {TMO_W{1'b1}});
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // AW and the WLAST beat may finish in either order or in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) state_d = XFER;
            XFER: begin
                if (tmo_fire) state_d = IDLE;
                else if ((aw_done_q || aw_hs) && (wlast_done_q || wlast_hs)) state_d = RESP;
            end
            RESP: if (tmo_fire || bus.BVALID) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.BREADY    = (state_q == RESP);
    end

    always_comb begin
        awvalid_d     = awvalid_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        awsize_d      = awsize_q;
        aw_done_d     = aw_done_q;
        wlast_done_d  = wlast_done_q;
        last_loaded_d = last_loaded_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        resp_d        = resp_q;
        if (state_q == IDLE && bus.req_valid) begin
            awvalid_d     = 1'b1;
            awaddr_d      = bus.req_addr;
            awlen_d       = bus.req_len;
            awsize_d      = bus.req_size;
            aw_done_d     = 1'b0;
            wlast_done_d  = 1'b0;
            last_loaded_d = 1'b0;
            cnt_d         = '0;
        end
        if (aw_hs) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
        end
        if (wlast_hs) wlast_done_d = 1'b1;
        // Counter is one bit wider than AWLEN so a 256-beat burst cannot wrap early.
        if (beat_hs) begin
            cnt_d = cnt_q + (LEN_W + 1)'(1);
            if (cnt_q == {1'b0, awlen_q}) last_loaded_d = 1'b1;
        end
        if (b_hs) begin
            done_d = 1'b1;
            resp_d = bus.BRESP;
        end
        if (tmo_fire) begin
            done_d    = 1'b1;
            resp_d    = RESP_SLVERR;
            awvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awsize_q      <= '0;
            aw_done_q     <= 1'b0;
            wlast_done_q  <= 1'b0;
            last_loaded_q <= 1'b0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            resp_q        <= RESP_OKAY;
        end else begin
            awvalid_q     <= awvalid_d;
            awaddr_q      <= awaddr_d;
            awlen_q       <= awlen_d;
            awsize_q      <= awsize_d;
            aw_done_q     <= aw_done_d;
            wlast_done_q  <= wlast_done_d;
            last_loaded_q <= last_loaded_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            resp_q        <= resp_d;
        end
    end

    assign bus.AWVALID = awvalid_q;
    assign bus.AWADDR  = awaddr_q;
    assign bus.AWID    = ID_W'(AXI_ID);
    assign bus.AWLEN   = awlen_q;
    assign bus.AWSIZE  = awsize_q;
    assign bus.AWBURST = BURST_INCR;
    assign bus.WVALID  = wvalid;
    assign bus.WDATA   = skid_out[DATA_W:1];
    assign bus.WSTRB   = skid_out[SKID_W-1:DATA_W+1];
    assign bus.WLAST   = wvalid && skid_out[0];
    assign bus.done    = done_q;
    assign bus.resp    = resp_q;

endmodule

// File: tb/tb_axi_write_master.sv
// Randomized directed bench for axi_write_master against a transaction-level reference model.
// With AXI_WR_TIMEOUT_EN defined it also exercises the watchdog abort.
module tb_axi_write_master;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int ID_W      = 4;
    localparam int LEN_W     = 8;
    localparam int STRB_W    = DATA_W / 8;
    localparam int CYC_LIMIT = 4000;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    axi_write_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

    axi_write_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .AXI_ID(0)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        bus.req_size   = '0;
        bus.beat_valid = 1'b0;
        bus.beat_data  = '0;
        bus.beat_strb  = '0;
        bus.AWREADY    = 1'b0;
        bus.WREADY     = 1'b0;
        bus.BVALID     = 1'b0;
        bus.BRESP      = 2'b00;
        bus.BID        = '0;
    endtask

    // One write transaction; cycle 0 is the first cycle after the request is accepted.
    task automatic run_txn(input logic [ADDR_W-1:0] addr, input int len, input logic [2:0] size,
                           input int aw_delay, input int wr_mode, input int bv_mode,
                           input logic [1:0] bresp, input bit junk, input int abort_at, input bit fixed);
        logic [DATA_W-1:0] dq[$];
        logic [STRB_W-1:0] sq[$];
        logic [DATA_W-1:0] held_d;
        logic [STRB_W-1:0] held_s;
        int bi, wi, cyc, hs_cyc, b_cyc, aw_cnt, bwait;
        bit aw_seen, wl_seen, b_seen, stall_w, stall_aw, fin, aborted;

        for (int i = 0; i <= len; i++) begin
            dq.push_back({$urandom, $urandom});
            sq.push_back(STRB_W'($urandom));
        end
        if (fixed) begin
            dq[0] = 64'hDEADBEEF_CAFEF00D;
            sq[0] = 8'hFF;
        end
        bi = 0; wi = 0; cyc = 0; hs_cyc = -1; b_cyc = -1; aw_cnt = 0;
        bwait = $urandom_range(0, 3);
        aw_seen = 0; wl_seen = 0; b_seen = 0; stall_w = 0; stall_aw = 0; fin = 0; aborted = 0;
        held_d = '0; held_s = '0;

        @(negedge ACLK);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = LEN_W'(len);
        bus.req_size  = size;
        #1;
        chk("req_ready_idle", bus.req_ready, 1'b1);
        chk("awvalid_idle", bus.AWVALID, 1'b0);

        while (!fin && !aborted && cyc < CYC_LIMIT) begin
            @(negedge ACLK);
            bus.req_valid = junk && !b_seen;
            if (junk) begin
                bus.req_addr = $urandom;
                bus.req_len  = LEN_W'($urandom);
            end
            bus.AWREADY = (cyc >= aw_delay);
            case (wr_mode)
                0:       bus.WREADY = 1'b1;
                1:       bus.WREADY = ($urandom_range(0, 1) == 1);
                2:       bus.WREADY = (cyc % 2 == 0);
                default: bus.WREADY = (cyc >= aw_delay);
            endcase
            bus.beat_valid = (bi <= len) && (bv_mode == 0 || $urandom_range(0, 2) != 0);
            if (bi <= len) begin
                bus.beat_data = dq[bi];
                bus.beat_strb = sq[bi];
            end else begin
                bus.beat_data = {$urandom, $urandom};
                bus.beat_strb = STRB_W'($urandom);
            end
            bus.BVALID = aw_seen && wl_seen && !b_seen && (cyc - hs_cyc > bwait);
            bus.BRESP  = bresp;
            bus.BID    = ID_W'($urandom);
            #1;

            if (cyc == 0) begin
                chk("aw_latency", bus.AWVALID, 1'b1);
                chk("req_ready_busy", bus.req_ready, 1'b0);
            end else if (junk && !b_seen) begin
                chk("req_ignored", bus.req_ready, 1'b0);
            end
            if (b_cyc >= 0 && cyc == b_cyc + 1) begin
                chk("done_pulse", bus.done, 1'b1);
                chk("done_resp", bus.resp, bresp);
                fin = 1;
            end else begin
                chk("done_quiet", bus.done, 1'b0);
            end
            if (hs_cyc >= 0 && cyc == hs_cyc + 1) chk("bready_resp", bus.BREADY, 1'b1);
            else if (hs_cyc < 0) chk("bready_xfer", bus.BREADY, 1'b0);

            if (stall_w) begin
                chk("w_hold_valid", bus.WVALID, 1'b1);
                chk("w_hold_data", bus.WDATA, held_d);
                chk("w_hold_strb", bus.WSTRB, held_s);
            end
            if (wr_mode == 0 && bv_mode == 0)
                chk("w_stream", bus.WVALID, (cyc >= 1 && cyc <= len + 1));
            if (bus.WVALID && bus.WREADY) begin
                if (wi <= len) begin
                    chk("wdata", bus.WDATA, dq[wi]);
                    chk("wstrb", bus.WSTRB, sq[wi]);
                    chk("wlast", bus.WLAST, (wi == len));
                    if (wi == len) wl_seen = 1;
                end else begin
                    chk("w_extra_beat", bus.WVALID, 1'b0);
                end
                if (abort_at == wi) aborted = 1;
                wi++;
            end
            stall_w = bus.WVALID && !bus.WREADY;
            held_d  = bus.WDATA;
            held_s  = bus.WSTRB;

            if (stall_aw) begin
                chk("aw_hold_valid", bus.AWVALID, 1'b1);
                chk("aw_hold_addr", bus.AWADDR, addr);
            end
            if (aw_seen) begin
                chk("aw_single", bus.AWVALID, 1'b0);
            end else if (bus.AWVALID && bus.AWREADY) begin
                chk("awaddr", bus.AWADDR, addr);
                chk("awlen", bus.AWLEN, len);
                chk("awsize", bus.AWSIZE, size);
                chk("awburst", bus.AWBURST, 2'b01);
                chk("awid", bus.AWID, 0);
                aw_seen = 1;
                aw_cnt++;
            end
            stall_aw = bus.AWVALID && !bus.AWREADY;

            if (hs_cyc < 0 && aw_seen && wl_seen) hs_cyc = cyc;
            if (bus.BVALID && bus.BREADY) begin
                b_seen = 1;
                b_cyc  = cyc;
            end
            if (bus.beat_valid && bus.beat_ready) bi++;
            cyc++;
        end

        if (aborted) begin
            @(negedge ACLK);
            drive_idle();
            ARESET = 1'b1;
            @(negedge ACLK);
            #1;
            chk("rst_awvalid", bus.AWVALID, 1'b0);
            chk("rst_wvalid", bus.WVALID, 1'b0);
            chk("rst_bready", bus.BREADY, 1'b0);
            chk("rst_req_ready", bus.req_ready, 1'b1);
            chk("rst_done", bus.done, 1'b0);
            ARESET = 1'b0;
            return;
        end

        chk("txn_finished", fin, 1'b1);
        chk("w_beat_count", wi, len + 1);
        chk("beats_consumed", bi, len + 1);
        chk("aw_count", aw_cnt, 1);
        @(negedge ACLK);
        drive_idle();
        #1;
        chk("done_single", bus.done, 1'b0);
        chk("idle_ready", bus.req_ready, 1'b1);
    endtask

    initial begin
        drive_idle();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        #1;
        chk("reset_req_ready", bus.req_ready, 1'b1);
        chk("reset_awvalid", bus.AWVALID, 1'b0);
        chk("reset_awaddr", bus.AWADDR, 0);
        chk("reset_wvalid", bus.WVALID, 1'b0);
        chk("reset_wlast", bus.WLAST, 1'b0);
        chk("reset_bready", bus.BREADY, 1'b0);
        chk("reset_beat_ready", bus.beat_ready, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_resp", bus.resp, 2'b00);
        ARESET = 1'b0;

        // single beat, all ready
        run_txn(32'h8000_0010, 0, 3'd3, 0, 0, 0, 2'b00, 1'b0, -1, 1'b1);
        // 4 beats complete before a late AW handshake
        run_txn(32'h0000_1000, 3, 3'd3, 5, 0, 0, 2'b00, 1'b1, -1, 1'b0);
        // 8 beats, WREADY 1010, gapped beat_valid
        run_txn(32'h0000_2040, 7, 3'd2, 2, 2, 1, 2'b01, 1'b0, -1, 1'b0);
        // AW and WLAST handshake together, SLVERR returned
        run_txn(32'h0000_3000, 0, 3'd3, 3, 3, 0, 2'b10, 1'b0, -1, 1'b0);
        // reset at beat 2 of an 8-beat burst, then a normal single beat
        run_txn(32'h0000_4000, 7, 3'd3, 1, 0, 0, 2'b00, 1'b0, 2, 1'b0);
        run_txn(32'h0000_5008, 0, 3'd3, 0, 0, 0, 2'b00, 1'b0, -1, 1'b0);
        // longest burst
        run_txn(32'h0001_0000, 255, 3'd3, 7, 1, 1, 2'b11, 1'b1, -1, 1'b0);
        run_txn(32'h0002_0000, 255, 3'd3, 300, 0, 0, 2'b00, 1'b0, -1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            run_txn($urandom, $urandom_range(0, 15), 3'($urandom_range(0, 3)),
                    $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 1),
                    2'($urandom), ($urandom_range(0, 1) == 1), -1, 1'b0);
        end

`ifdef AXI_WR_TIMEOUT_EN
        begin : tmo_test
            int c, lastw, donec;
            @(negedge ACLK);
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'h0000_6000;
            bus.req_len   = '0;
            bus.req_size  = 3'd3;
            c = 0; lastw = -1; donec = -1;
            while (donec < 0 && c < 70000) begin
                @(negedge ACLK);
                bus.req_valid  = 1'b0;
                bus.AWREADY    = 1'b1;
                bus.WREADY     = 1'b1;
                bus.beat_valid = (c == 0);
                bus.beat_data  = {$urandom, $urandom};
                bus.beat_strb  = '1;
                bus.BVALID     = 1'b0;
                #1;
                if (bus.done) donec = c;
                if (bus.WVALID && bus.WREADY) lastw = c;
                c++;
            end
            chk("tmo_fired", (donec >= 0), 1'b1);
            chk("tmo_resp", bus.resp, 2'b10);
            chk("tmo_delay_window", (donec - lastw >= 65533 && donec - lastw <= 65539), 1'b1);
            @(negedge ACLK);
            drive_idle();
            #1;
            chk("tmo_awvalid", bus.AWVALID, 1'b0);
            chk("tmo_wvalid", bus.WVALID, 1'b0);
            chk("tmo_bready", bus.BREADY, 1'b0);
            chk("tmo_req_ready", bus.req_ready, 1'b1);
            chk("tmo_done_once", bus.done, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
